// File: rtl/regs.sv
// Small register file: four writable GPRs plus constant, switch and
// reserved sources, with two combinational read ports and an LED tap on gpr[3].
module regs #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         w,
  input  logic [n-1:0] Wdata,
  input  logic [8:0]   SW,
  input  logic [2:0]   Raddr1,
  input  logic [2:0]   Raddr2,
  output logic [n-1:0] Rdata1,
  output logic [n-1:0] Rdata2,
  output logic [7:0]   out
);

  logic [n-1:0] gpr_reg [4];
  logic [3:0]   wr_en;
  logic [n-1:0] src [8];

  // Raddr2 doubles as the write target; only %1..%4 map onto storage.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wr_en
      assign wr_en[gi] = w && (Raddr2 == 3'(gi + 1));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!nReset) begin
      for (int i = 0; i < 4; i++) gpr_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_en[i]) gpr_reg[i] <= Wdata;
      end
    end
  end

  // Switch sources are live, so they follow SW even while in reset.
  always_comb begin
    src[0] = '0;
    for (int i = 1; i <= 4; i++) src[i] = gpr_reg[i-1];
    src[5]      = '0;
    src[5][7:0] = SW[7:0];
    src[6]      = '0;
    src[6][0]   = SW[8];
    src[7]      = '0;
  end

  assign Rdata1 = src[Raddr1];
  assign Rdata2 = src[Raddr2];
  assign out    = gpr_reg[3][7:0];

endmodule

// File: tb/tb_regs.sv
// Self-checking bench for regs: directed scenarios followed by randomized
// traffic, all checked against an array-based reference model.
module tb_regs;
  localparam int N = 8;

  logic         clk;
  logic         nReset;
  logic         w;
  logic [N-1:0] Wdata;
  logic [8:0]   SW;
  logic [2:0]   Raddr1;
  logic [2:0]   Raddr2;
  logic [N-1:0] Rdata1;
  logic [N-1:0] Rdata2;
  logic [7:0]   out;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] model [4];

  regs #(.n(N)) dut (
    .clk(clk), .nReset(nReset), .w(w), .Wdata(Wdata), .SW(SW),
    .Raddr1(Raddr1), .Raddr2(Raddr2), .Rdata1(Rdata1), .Rdata2(Rdata2), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference read: what the address map says each address returns.
  function automatic logic [N-1:0] ref_read(input int addr);
    logic [N-1:0] v;
    v = '0;
    if (addr >= 1 && addr <= 4) v = model[addr-1];
    else if (addr == 5) v = N'(SW[7:0]);
    else if (addr == 6) v = N'(SW[8]);
    return v;
  endfunction

  // One transaction: check reads before the edge, clock, update model, check after.
  task automatic cycle(input string tag);
    #1;
    check({tag, " r1 pre"}, 32'(Rdata1), 32'(ref_read(int'(Raddr1))));
    check({tag, " r2 pre"}, 32'(Rdata2), 32'(ref_read(int'(Raddr2))));
    @(posedge clk);
    if (!nReset) begin
      for (int i = 0; i < 4; i++) model[i] = '0;
    end else if (w && Raddr2 >= 3'd1 && Raddr2 <= 3'd4) begin
      model[int'(Raddr2) - 1] = Wdata;
    end
    #1;
    check({tag, " r1 post"}, 32'(Rdata1), 32'(ref_read(int'(Raddr1))));
    check({tag, " r2 post"}, 32'(Rdata2), 32'(ref_read(int'(Raddr2))));
    check({tag, " out"},     32'(out),    32'(model[3][7:0]));
    $display("%0t %s rst_n=%b w=%b wd=%h sw=%h a1=%0d a2=%0d rd1=%h rd2=%h out=%h",
             $time, tag, nReset, w, Wdata, SW, Raddr1, Raddr2, Rdata1, Rdata2, out);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) model[i] = $urandom;
    nReset = 1'b0; w = 1'b0; Wdata = '0; SW = '0; Raddr1 = 3'd0; Raddr2 = 3'd0;
    @(posedge clk); #1;
    cycle("reset");

    // Switch reads after reset
    nReset = 1'b1; w = 1'b0; SW = 9'b1_0000_0100; Raddr1 = 3'd6; Raddr2 = 3'd0;
    cycle("sw");
    check("sw rd1", 32'(Rdata1), 32'h01);
    check("sw rd2", 32'(Rdata2), 32'h00);
    check("sw out", 32'(out), 32'h00);

    // Write %1: old value until the edge
    w = 1'b1; Wdata = 8'h03; Raddr1 = 3'd5; Raddr2 = 3'd1;
    #1;
    check("wr1 pre rd1", 32'(Rdata1), 32'h04);
    check("wr1 pre rd2", 32'(Rdata2), 32'h00);
    cycle("wr1");
    check("wr1 post rd2", 32'(Rdata2), 32'h03);

    // Write %4 drives LEDs
    Wdata = 8'h17; Raddr1 = 3'd1; Raddr2 = 3'd4;
    cycle("wr4");
    check("wr4 rd1", 32'(Rdata1), 32'h03);
    check("wr4 out", 32'(out), 32'h17);

    // Writes to non-storage addresses are dropped
    Wdata = 8'hFF;
    for (int a = 0; a < 8; a++) begin
      if (a != 0 && a < 5) continue;
      Raddr2 = 3'(a); Raddr1 = 3'(a);
      cycle("wr_ign");
      check("wr_ign out", 32'(out), 32'h17);
    end

    // Set gpr[1], then reset wins over a concurrent write
    Wdata = 8'h5A; Raddr2 = 3'd2; cycle("wr2");
    nReset = 1'b0; Wdata = 8'hAA; Raddr1 = 3'd2; Raddr2 = 3'd2;
    cycle("rst_wr");
    check("rst_wr rd2", 32'(Rdata2), 32'h00);
    check("rst_wr out", 32'(out), 32'h00);
    nReset = 1'b1;

    // w=0 holds gpr[2]
    w = 1'b1; Wdata = 8'h3C; Raddr2 = 3'd3; cycle("wr3");
    w = 1'b0; Wdata = 8'h55; Raddr1 = 3'd3;
    for (int k = 0; k < 4; k++) cycle("hold");
    check("hold rd2", 32'(Rdata2), 32'h3C);

    // Random traffic
    for (int k = 0; k < 250; k++) begin
      nReset = ($urandom_range(0, 15) != 0);
      w      = 1'($urandom);
      Wdata  = N'($urandom);
      SW     = 9'($urandom);
      Raddr1 = 3'($urandom);
      Raddr2 = ($urandom_range(0, 3) == 0) ? Raddr1 : 3'($urandom);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
